// File: rtl/mapper_pkg.sv
// mapper_pkg: shared constants and types for the bank/page memory mapper.
//   - register window geometry
//   - mapper entry field positions
//   - write FSM state encoding
//   - passthrough mapped-bank mask
package mapper_pkg;

   localparam logic [15:0] WIN_BASE_DEFAULT = 16'h4000;
   localparam int unsigned WIN_SIZE         = 32;
   localparam int unsigned NUM_REGS         = 16;

   // Entry layout: mapped[8], readonly[7], page[6:0]
   localparam int unsigned MAP_BIT  = 8;
   localparam int unsigned RO_BIT   = 7;
   localparam int unsigned PAGE_MSB = 6;

   // Banks 2, 3 and A..F are backed by SRAM when mapping is disabled
   localparam logic [15:0] PASS_MAP_MASK = 16'hFC0C;

   typedef logic [MAP_BIT:0] map_entry_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOW_HELD = 2'd1,
      COMMIT   = 2'd2
   } wr_state_e;

   // Byte view of an entry as seen by the CPU: odd lane = page, even lane = flags
   function automatic logic [7:0] entry_byte(input map_entry_t e, input logic odd);
      logic [7:0] b;
      if (odd) begin
         b = {1'b0, e[PAGE_MSB:0]};
      end else begin
         b = {e[MAP_BIT], e[RO_BIT], 6'b0};
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer (reset value 1) with a registered
// falling-edge pulse aligned to the cycle the synchronized output goes low.
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   i_d     in  asynchronous input
//   o_q     out synchronized level
//   o_fall  out one-cycle pulse on synchronized 1->0 transition
module sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic i_d,
   output logic o_q,
   output logic o_fall
);

   logic r_s1;
   logic r_s2;
   logic r_fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1   <= 1'b1;
         r_s2   <= 1'b1;
         r_fall <= 1'b0;
      end else begin
         r_s1   <= i_d;
         r_s2   <= r_s1;
         // r_s2 is about to take the low value held in r_s1
         r_fall <= r_s2 & ~r_s1;
      end
   end

   assign o_q    = r_s2;
   assign o_fall = r_fall;

endmodule

// File: rtl/memory_mapper.sv
// memory_mapper: 16-entry bank/page register file for the SRAM interface.
//   Lookup (combinational): bank_sel -> bank_address / bank_mapped / bank_readonly,
//     from the registers when cru_map_en=1, else fixed passthrough mapping.
//   Programming: CPU byte writes into the 32-byte window at WIN_BASE, odd byte
//     (page) first, even byte (flags) second; committed as one 9-bit entry.
//   Readback: combinational, rd_hit tells the host to drive rd_data.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   bank_sel                     bank index (cpu_addr[15:12])
//   bank_mapped/readonly/address lookup result
//   cpu_addr, i_data_bus         CPU address and data byte
//   memen, we, dbin, a15         CPU strobes and byte lane
//   cru_regs_en, cru_map_en      CRU control bits
//   rd_hit, rd_data              register readback
//   wr_busy                      first byte of a register write is held
module memory_mapper
   import mapper_pkg::*;
#(
   parameter logic [15:0] WIN_BASE     = WIN_BASE_DEFAULT,
   parameter logic [2:0]  PASS_PAGE_HI = 3'b000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  bank_sel,
   output logic        bank_mapped,
   output logic        bank_readonly,
   output logic [6:0]  bank_address,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  i_data_bus,
   input  logic        memen,
   input  logic        we,
   input  logic        dbin,
   input  logic        a15,
   input  logic        cru_regs_en,
   input  logic        cru_map_en,
   output logic        rd_hit,
   output logic [7:0]  rd_data,
   output logic        wr_busy
);

   map_entry_t  r_regs [NUM_REGS];
   wr_state_e   r_state;
   wr_state_e   w_state_next;
   logic [3:0]  r_idx;
   logic [6:0]  r_lo_page;
   logic [1:0]  r_hi_flags;

   logic        w_memen_s;
   logic        w_memen_fall;
   logic        w_we_s;
   logic        w_we_fall;
   logic        w_a15_s;
   logic        w_a15_fall;
   logic        w_unused;

   logic        w_hit;
   logic [3:0]  w_idx;
   logic        w_lo_load;
   logic        w_hi_load;
   logic        w_commit;
   map_entry_t  w_lookup;
   map_entry_t  w_rd_entry;

   sync_edge u_sync_memen (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (memen),
      .o_q     (w_memen_s),
      .o_fall  (w_memen_fall)
   );

   sync_edge u_sync_we (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (we),
      .o_q     (w_we_s),
      .o_fall  (w_we_fall)
   );

   sync_edge u_sync_a15 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (a15),
      .o_q     (w_a15_s),
      .o_fall  (w_a15_fall)
   );

   assign w_unused = w_memen_fall ^ w_a15_fall ^ w_we_s ^ cpu_addr[0];

   assign w_hit = cru_regs_en && (cpu_addr[15:5] == WIN_BASE[15:5]);
   assign w_idx = cpu_addr[4:1];

   // Write FSM next-state
   always_comb begin
      w_state_next = r_state;
      w_lo_load    = 1'b0;
      w_hi_load    = 1'b0;
      w_commit     = 1'b0;
      unique case (r_state)
         IDLE: begin
            // An even byte arriving first is not a valid write and is dropped
            if (w_we_fall && !w_memen_s && w_hit && w_a15_s) begin
               w_lo_load    = 1'b1;
               w_state_next = LOW_HELD;
            end
         end
         LOW_HELD: begin
            if (w_memen_s || !w_hit || (w_idx != r_idx)) begin
               w_state_next = IDLE;
            end else if (w_we_fall && !w_a15_s) begin
               w_hi_load    = 1'b1;
               w_state_next = COMMIT;
            end
         end
         COMMIT: begin
            w_commit     = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_idx      <= 4'd0;
         r_lo_page  <= 7'd0;
         r_hi_flags <= 2'd0;
      end else begin
         r_state <= w_state_next;
         if (w_lo_load) begin
            r_idx     <= w_idx;
            r_lo_page <= i_data_bus[PAGE_MSB:0];
         end
         if (w_hi_load) begin
            r_hi_flags <= i_data_bus[7:6];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[r_idx] <= {r_hi_flags, r_lo_page};
      end
   end

   assign wr_busy = (r_state == LOW_HELD);

   // Lookup path; during COMMIT the old entry is still visible
   assign w_lookup = r_regs[bank_sel];

   always_comb begin
      bank_mapped   = 1'b0;
      bank_readonly = 1'b0;
      bank_address  = {PASS_PAGE_HI, bank_sel};
      if (cru_map_en) begin
         bank_mapped   = w_lookup[MAP_BIT];
         bank_readonly = w_lookup[RO_BIT];
         bank_address  = w_lookup[PAGE_MSB:0];
      end else begin
         bank_mapped   = PASS_MAP_MASK[bank_sel];
      end
   end

   // Readback uses the raw strobes so it answers within the current bus cycle
   assign w_rd_entry = r_regs[w_idx];
   assign rd_hit     = w_hit && !memen && dbin;
   assign rd_data    = entry_byte(w_rd_entry, a15);

endmodule

// File: tb/tb_memory_mapper.sv
module tb_memory_mapper;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  bank_sel;
   logic        bank_mapped;
   logic        bank_readonly;
   logic [6:0]  bank_address;
   logic [15:0] cpu_addr;
   logic [7:0]  i_data_bus;
   logic        memen;
   logic        we;
   logic        dbin;
   logic        a15;
   logic        cru_regs_en;
   logic        cru_map_en;
   logic        rd_hit;
   logic [7:0]  rd_data;
   logic        wr_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: entries as {mapped, readonly, page}
   logic [8:0] m_regs [16];

   typedef struct {
      logic [3:0] bsel;
      logic       exp_mapped;
      logic       exp_ro;
      logic [6:0] exp_addr;
   } vec_t;

   vec_t vecs [16];

   memory_mapper dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bank_sel      (bank_sel),
      .bank_mapped   (bank_mapped),
      .bank_readonly (bank_readonly),
      .bank_address  (bank_address),
      .cpu_addr      (cpu_addr),
      .i_data_bus    (i_data_bus),
      .memen         (memen),
      .we            (we),
      .dbin          (dbin),
      .a15           (a15),
      .cru_regs_en   (cru_regs_en),
      .cru_map_en    (cru_map_en),
      .rd_hit        (rd_hit),
      .rd_data       (rd_data),
      .wr_busy       (wr_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic pass_mapped(input logic [3:0] b);
      return (b == 4'd2) || (b == 4'd3) || (b >= 4'd10);
   endfunction

   task automatic write_byte(input logic odd, input logic [7:0] d);
      a15        = odd;
      i_data_bus = d;
      repeat (3) @(negedge clk);
      we = 1'b0;
      repeat (4) @(negedge clk);
      we = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic write_word(input logic [15:0] addr, input logic [7:0] lo, input logic [7:0] hi);
      cpu_addr = addr;
      memen    = 1'b0;
      write_byte(1'b1, lo);
      write_byte(1'b0, hi);
      memen = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_lookup(input string name, input logic [3:0] b);
      logic       em;
      logic       er;
      logic [6:0] ea;
      bank_sel = b;
      #1;
      if (cru_map_en) begin
         em = m_regs[b][8];
         er = m_regs[b][7];
         ea = m_regs[b][6:0];
      end else begin
         em = pass_mapped(b);
         er = 1'b0;
         ea = {3'b000, b};
      end
      check({name, "_mapped"}, bank_mapped, em);
      check({name, "_ro"}, bank_readonly, er);
      check({name, "_addr"}, bank_address, ea);
   endtask

   task automatic check_read(input string name, input logic [3:0] idx, input logic odd);
      cpu_addr = 16'h4000 + 16'(idx) * 16'd2;
      memen    = 1'b0;
      dbin     = 1'b1;
      a15      = odd;
      #1;
      check({name, "_hit"}, rd_hit, cru_regs_en);
      if (cru_regs_en) begin
         check({name, "_data"}, rd_data,
               odd ? {1'b0, m_regs[idx][6:0]} : {m_regs[idx][8:7], 6'b0});
      end
      @(negedge clk);
      memen = 1'b1;
      dbin  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset_n     = 1'b0;
      bank_sel    = 4'd0;
      cpu_addr    = 16'h0000;
      i_data_bus  = 8'h00;
      memen       = 1'b1;
      we          = 1'b1;
      dbin        = 1'b0;
      a15         = 1'b1;
      cru_regs_en = 1'b0;
      cru_map_en  = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 9'h000;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("reset_wr_busy", wr_busy, 1'b0);
      check("reset_rd_hit", rd_hit, 1'b0);

      // Passthrough sweep
      for (int i = 0; i < 16; i++) begin
         vecs[i].bsel       = 4'(i);
         vecs[i].exp_mapped = pass_mapped(4'(i));
         vecs[i].exp_ro     = 1'b0;
         vecs[i].exp_addr   = 7'(i);
      end
      for (int i = 0; i < 16; i++) begin
         bank_sel = vecs[i].bsel;
         #1;
         check($sformatf("pass_mapped_%0d", i), bank_mapped, vecs[i].exp_mapped);
         check($sformatf("pass_ro_%0d", i), bank_readonly, vecs[i].exp_ro);
         check($sformatf("pass_addr_%0d", i), bank_address, vecs[i].exp_addr);
      end

      // Register 3 write and lookup
      cru_regs_en = 1'b1;
      @(negedge clk);
      write_word(16'h4006, 8'h25, 8'hC0);
      m_regs[3] = 9'b1_1_0100101;
      cru_map_en = 1'b1;
      bank_sel   = 4'd3;
      #1;
      check("reg3_addr", bank_address, 7'h25);
      check("reg3_mapped", bank_mapped, 1'b1);
      check("reg3_ro", bank_readonly, 1'b1);
      @(negedge clk);

      // Readback
      cpu_addr = 16'h4006;
      memen    = 1'b0;
      dbin     = 1'b1;
      a15      = 1'b1;
      #1;
      check("rd_odd_hit", rd_hit, 1'b1);
      check("rd_odd_data", rd_data, 8'h25);
      a15 = 1'b0;
      #1;
      check("rd_even_hit", rd_hit, 1'b1);
      check("rd_even_data", rd_data, 8'hC0);
      cru_regs_en = 1'b0;
      #1;
      check("rd_disabled_hit", rd_hit, 1'b0);
      dbin  = 1'b0;
      memen = 1'b1;
      cru_regs_en = 1'b1;
      repeat (3) @(negedge clk);

      // Odd byte then memen high: abort
      cpu_addr = 16'h4010;
      memen    = 1'b0;
      write_byte(1'b1, 8'h5A);
      check("abort_busy_held", wr_busy, 1'b1);
      memen = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_busy_clear", wr_busy, 1'b0);
      // Lone even byte in IDLE: ignored
      memen = 1'b0;
      write_byte(1'b0, 8'hC0);
      check("lone_even_busy", wr_busy, 1'b0);
      memen = 1'b1;
      repeat (3) @(negedge clk);
      check_lookup("reg8_after_abort", 4'd8);

      // Writes that must not land
      cru_regs_en = 1'b0;
      @(negedge clk);
      write_word(16'h4008, 8'h11, 8'hC0);
      check_lookup("reg4_regs_dis", 4'd4);
      cru_regs_en = 1'b1;
      @(negedge clk);
      write_word(16'h4020, 8'h12, 8'hC0);
      check_lookup("reg0_outside", 4'd0);

      // Commit latency: old value visible in COMMIT, new value afterwards
      cpu_addr = 16'h400A;
      memen    = 1'b0;
      bank_sel = 4'd5;
      write_byte(1'b1, 8'h3A);
      a15        = 1'b0;
      i_data_bus = 8'h80;
      repeat (3) @(negedge clk);
      we = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("lat_busy_fall_cycle", wr_busy, 1'b1);
      @(posedge clk);
      #1;
      check("lat_commit_busy", wr_busy, 1'b0);
      check("lat_commit_old_mapped", bank_mapped, 1'b0);
      check("lat_commit_old_addr", bank_address, 7'h00);
      @(posedge clk);
      #1;
      check("lat_new_mapped", bank_mapped, 1'b1);
      check("lat_new_ro", bank_readonly, 1'b0);
      check("lat_new_addr", bank_address, 7'h3A);
      @(negedge clk);
      we    = 1'b1;
      memen = 1'b1;
      m_regs[5] = 9'b1_0_0111010;
      repeat (3) @(negedge clk);

      // Randomized writes and checks against the model
      for (int it = 0; it < 40; it++) begin
         logic [3:0]  idx;
         logic [7:0]  lo;
         logic [7:0]  hi;
         logic        en;
         logic        inwin;
         logic [15:0] addr;
         idx   = 4'($urandom_range(0, 15));
         lo    = 8'($urandom);
         hi    = 8'($urandom);
         en    = ($urandom_range(0, 3) != 0);
         inwin = ($urandom_range(0, 3) != 0);
         addr  = inwin ? 16'h4000 + 16'(idx) * 16'd2 : 16'h4020 + 16'(idx) * 16'd2;
         cru_regs_en = en;
         @(negedge clk);
         write_word(addr, lo, hi);
         if (en && inwin) m_regs[idx] = {hi[7], hi[6], lo[6:0]};
         for (int k = 0; k < 2; k++) begin
            cru_map_en = 1'($urandom_range(0, 1));
            check_lookup($sformatf("rnd%0d_lk%0d", it, k), 4'($urandom_range(0, 15)));
         end
         cru_regs_en = 1'($urandom_range(0, 1));
         check_read($sformatf("rnd%0d_rd", it), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
      end

      // Reset while holding the low byte
      cru_regs_en = 1'b1;
      @(negedge clk);
      cpu_addr = 16'h4010;
      memen    = 1'b0;
      write_byte(1'b1, 8'h11);
      check("rst_busy_before", wr_busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_busy_after", wr_busy, 1'b0);
      for (int i = 0; i < 16; i++) m_regs[i] = 9'h000;
      cru_map_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bank_sel = 4'(i);
         #1;
         check($sformatf("rst_mapped_%0d", i), bank_mapped, 1'b0);
         check($sformatf("rst_addr_%0d", i), bank_address, 7'h00);
      end
      memen = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_release_busy", wr_busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
